memory_control: RTL and testbench
=================================

Name: memory_control

Overview:
- Responder end of the cache-to-memory request interface. It arbitrates the dcache and icache request ports of N_CORES cores onto the single RAM port.
- It drives `dwait`/`iwait` and `dload`/`iload` back to the caches; the caches are the initiators and hold their request until their wait is low.
- Sits between the per-core caches and RAM, below the cache layer.

Parameters:
- N_CORES, 2, number of cores; each core has one dcache port and one icache port.
- CID_W, 1, core-id width, equal to clog2(N_CORES), minimum 1.

Ports:
- CLK  input  1  clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- dREN  input  N_CORES  per-core dcache read request.
- dWEN  input  N_CORES  per-core dcache write request.
- daddr  input  N_CORES x 32  per-core dcache word address.
- dstore  input  N_CORES x 32  per-core dcache write data.
- iREN  input  N_CORES  per-core icache read request.
- iaddr  input  N_CORES x 32  per-core icache address.
- dwait  output  N_CORES  per-core dcache wait; low for exactly the completing cycle.
- dload  output  N_CORES x 32  per-core dcache read data, valid when dwait is low.
- iwait  output  N_CORES  per-core icache wait.
- iload  output  N_CORES x 32  per-core icache read data.
- ramREN  output  1  RAM read enable.
- ramWEN  output  1  RAM write enable.
- ramaddr  output  32  RAM address.
- ramstore  output  32  RAM write data.
- ramload  input  32  RAM read data.
- ramstate  input  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

Behaviour:
- Reset:
  - state = IDLE, rr_ptr = 0, owner cleared.
  - All dwait/iwait = 1, all loads = 0, ramREN = ramWEN = 0, ramaddr = ramstore = 0.
  - Reset mid-transaction aborts it immediately; no completion is signalled.
- States: IDLE, DBUS, IBUS.
- IDLE:
  - No RAM drive; all waits 1.
  - Selects one pending request and registers owner (core id, kind).
  - Priority: any dcache request (dREN|dWEN) beats any icache request.
  - Within a kind, round-robin starts at rr_ptr.
  - Goes to DBUS or IBUS on the next edge. No requests: stay in IDLE.
- DBUS:
  - Drives RAM from the owner's live dcache signals.
  - If dWEN and dREN are both high, write wins: ramWEN = 1, ramREN = 0, ramstore = dstore.
  - ramaddr = owner daddr.
- IBUS:
  - ramREN = 1, ramaddr = owner iaddr.
- Completion (both bus states):
  - When ramstate == ACCESS, the owner's wait = 0 and its load = ramload, combinationally in the same cycle.
  - Next state IDLE; rr_ptr = owner core + 1 mod N_CORES.
- Stall conditions:
  - ramstate FREE/BUSY: stay in the state, waits stay 1.
  - ramstate ERROR: same as BUSY, treated as a stall and never a completion.
- Owner drops its request while in DBUS/IBUS (protocol violation): return to IDLE next edge, no wait-low pulse, rr_ptr unchanged.
- Non-owner ports always see wait = 1 and load = 0. Only one wait is low in any cycle.
- Latency: request at cycle t, RAM driven from t+1; earliest completion is t+1 with a single-cycle ACCESS.
- Back-to-back: after completion there is a mandatory IDLE cycle, so the next grant's RAM drive starts 2 cycles after the previous ACCESS.
- Fairness:
  - A core's dcache cannot win twice in a row while another core's dcache is pending.
  - An icache can starve only under continuous dcache traffic; this is accepted.

Optional Feature:
- Macro: MEMORY_CONTROL_STATS_EN.
- Defined:
  - Adds output `bus_busy_cycles` (32) and output `bus_xfers` (32).
  - `bus_busy_cycles` increments every cycle state != IDLE.
  - `bus_xfers` increments on each ACCESS completion.
  - Both reset to 0 and wrap at 2^32.
- Undefined: both ports exist and are tied to 0; no counter flops.

Decomposition:
- cpu_types_pkg provides word_t and ramstate_t. Add to it:
  - memctl_state_t {IDLE, DBUS, IBUS}.
  - a bus-owner struct {cid, is_icache}.
- One natural sub-module, rr_arbiter: N-input round-robin picker with a pointer input and a grant-index plus valid output. It is instantiated twice, once for dcache requests and once for icache requests.

Test Plan:
- Single-request timing: core0 dREN, daddr=0x100; RAM returns BUSY for 2 cycles, then ACCESS with ramload=0xDEADBEEF → dwait[0] low exactly one cycle, dload[0]=0xDEADBEEF, ramREN=1, ramaddr=0x100 for 3 cycles.
- dcache priority: core0 iREN and core1 dWEN at 0x3100 with dstore=0x5 in the same cycle → core1 write served first with ramWEN=1, ramstore=0x5; the icache is served after the IDLE gap.
- Round-robin: both dcaches request continuously for 4 transactions → grant order core0, core1, core0, core1.
- Read/write conflict: dREN=dWEN=1 on core1 → only ramWEN asserted; completion pulses dwait[1].
- Stall behaviour: ramstate=ERROR for 5 cycles then ACCESS → all waits remain 1 during ERROR and the owner completes on ACCESS. Separately, owner drops dREN mid-BUSY → return to IDLE, no wait pulse.
- Reset and stats: assert n_rst low during DBUS → all outputs at reset values immediately. With MEMORY_CONTROL_STATS_EN, 3 transfers with 2 busy cycles each → bus_xfers=3, bus_busy_cycles=6.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM word and handshake state, memory-controller
// FSM states and the bus-owner record.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DBUS = 2'd1,
    IBUS = 2'd2
  } memctl_state_t;

  // Widest core id the owner record can hold; the controller uses CID_W of it.
  localparam int unsigned CidMaxW = 8;

  typedef struct packed {
    logic [CidMaxW-1:0] cid;
    logic               is_icache;
  } bus_owner_t;

endpackage

// File: rtl/memory_control_rr_arbiter.sv
// N-input round-robin picker: grants the first set request at or after the
// pointer, wrapping to index 0.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned CID_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [CID_W-1:0] ptr_i,
  output logic [CID_W-1:0] gnt_o,
  output logic             valid_o
);

  logic [31:0] ptr_ext;
  assign ptr_ext = {{(32 - CID_W){1'b0}}, ptr_i};

  // First pass scans from the pointer upward, second pass covers the wrap.
  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!valid_o && req_i[j] && (j >= ptr_ext)) begin
        valid_o = 1'b1;
        gnt_o   = CID_W'(j);
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!valid_o && req_i[j]) begin
        valid_o = 1'b1;
        gnt_o   = CID_W'(j);
      end
    end
  end

endmodule

// File: rtl/memory_control.sv
// Arbitrates the dcache/icache request ports of N_CORES cores onto one RAM
// port. Dcache requests beat icache requests; round-robin within each kind.
// Optional MEMORY_CONTROL_STATS_EN adds busy-cycle and transfer counters;
// without it bus_busy_cycles/bus_xfers are tied to zero.
module memory_control
  import cpu_types_pkg::*;
#(
  parameter int unsigned N_CORES = 2,
  parameter int unsigned CID_W   = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                      CLK,
  input  logic                      n_rst,
  input  logic [N_CORES-1:0]        dREN,
  input  logic [N_CORES-1:0]        dWEN,
  input  logic [N_CORES-1:0][31:0]  daddr,
  input  logic [N_CORES-1:0][31:0]  dstore,
  input  logic [N_CORES-1:0]        iREN,
  input  logic [N_CORES-1:0][31:0]  iaddr,
  output logic [N_CORES-1:0]        dwait,
  output logic [N_CORES-1:0][31:0]  dload,
  output logic [N_CORES-1:0]        iwait,
  output logic [N_CORES-1:0][31:0]  iload,
  output logic                      ramREN,
  output logic                      ramWEN,
  output word_t                     ramaddr,
  output word_t                     ramstore,
  input  word_t                     ramload,
  input  ramstate_t                 ramstate,
  output logic [31:0]               bus_busy_cycles,
  output logic [31:0]               bus_xfers
);

  memctl_state_t    state_q, state_d;
  bus_owner_t       owner_q, owner_d;
  logic [CID_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [N_CORES-1:0] d_req;
  logic [CID_W-1:0]   d_gnt, i_gnt;
  logic               d_vld, i_vld;

  assign d_req = dREN | dWEN;

  rr_arbiter #(
    .N     (N_CORES),
    .CID_W (CID_W)
  ) u_d_arb (
    .req_i   (d_req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (d_gnt),
    .valid_o (d_vld)
  );

  rr_arbiter #(
    .N     (N_CORES),
    .CID_W (CID_W)
  ) u_i_arb (
    .req_i   (iREN),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (i_gnt),
    .valid_o (i_vld)
  );

  // State, owner and round-robin pointer registers.
  always_ff @(posedge CLK or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Grant selection in IDLE; RAM drive and same-cycle completion in bus states.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    dwait    = '1;
    iwait    = '1;
    dload    = '0;
    iload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    unique case (state_q)
      IDLE: begin
        if (d_vld) begin
          owner_d.cid       = CidMaxW'(d_gnt);
          owner_d.is_icache = 1'b0;
          state_d           = DBUS;
        end else if (i_vld) begin
          owner_d.cid       = CidMaxW'(i_gnt);
          owner_d.is_icache = 1'b1;
          state_d           = IBUS;
        end
      end

      DBUS, IBUS: begin
        for (int unsigned c = 0; c < N_CORES; c++) begin
          if (owner_q.cid == CidMaxW'(c)) begin
            if (owner_q.is_icache) begin
              // A dropped request abandons the grant without a wait pulse.
              if (!iREN[c]) begin
                state_d = IDLE;
              end else begin
                ramREN  = 1'b1;
                ramaddr = iaddr[c];
                if (ramstate == ACCESS) begin
                  iwait[c] = 1'b0;
                  iload[c] = ramload;
                  state_d  = IDLE;
                  rr_ptr_d = CID_W'((c + 1) % N_CORES);
                end
              end
            end else begin
              if (!(dREN[c] || dWEN[c])) begin
                state_d = IDLE;
              end else begin
                ramaddr = daddr[c];
                // Write wins when the cache raises both enables.
                if (dWEN[c]) begin
                  ramWEN   = 1'b1;
                  ramstore = dstore[c];
                end else begin
                  ramREN = 1'b1;
                end
                if (ramstate == ACCESS) begin
                  dwait[c] = 1'b0;
                  dload[c] = ramload;
                  state_d  = IDLE;
                  rr_ptr_d = CID_W'((c + 1) % N_CORES);
                end
              end
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef MEMORY_CONTROL_STATS_EN
  logic [31:0] busy_cnt_q, busy_cnt_d;
  logic [31:0] xfer_cnt_q, xfer_cnt_d;

  // A completion is exactly a cycle in which some wait is low.
  always_comb begin
    busy_cnt_d = busy_cnt_q + ((state_q != IDLE) ? 32'd1 : 32'd0);
    xfer_cnt_d = xfer_cnt_q + ((~&{dwait, iwait}) ? 32'd1 : 32'd0);
  end

  // Statistics counters, free-running with wrap-around.
  always_ff @(posedge CLK or negedge n_rst) begin
    if (!n_rst) begin
      busy_cnt_q <= '0;
      xfer_cnt_q <= '0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign bus_busy_cycles = busy_cnt_q;
  assign bus_xfers       = xfer_cnt_q;
`else
  assign bus_busy_cycles = '0;
  assign bus_xfers       = '0;
`endif

endmodule

// File: tb/tb_memory_control.sv
// Self-checking bench for memory_control: directed scenarios followed by
// randomized cache/RAM traffic, all compared against a transaction-level model.
module tb_memory_control;
  import cpu_types_pkg::*;

  localparam int N  = 2;
  localparam int CW = 1;
`ifdef MEMORY_CONTROL_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic                CLK;
  logic                n_rst;
  logic [N-1:0]        dREN, dWEN, iREN;
  logic [N-1:0][31:0]  daddr, dstore, iaddr;
  logic [N-1:0]        dwait, iwait;
  logic [N-1:0][31:0]  dload, iload;
  logic                ramREN, ramWEN;
  word_t               ramaddr, ramstore, ramload;
  ramstate_t           ramstate;
  logic [31:0]         bus_busy_cycles, bus_xfers;

  memory_control #(
    .N_CORES (N),
    .CID_W   (CW)
  ) dut (
    .CLK             (CLK),
    .n_rst           (n_rst),
    .dREN            (dREN),
    .dWEN            (dWEN),
    .daddr           (daddr),
    .dstore          (dstore),
    .iREN            (iREN),
    .iaddr           (iaddr),
    .dwait           (dwait),
    .dload           (dload),
    .iwait           (iwait),
    .iload           (iload),
    .ramREN          (ramREN),
    .ramWEN          (ramWEN),
    .ramaddr         (ramaddr),
    .ramstore        (ramstore),
    .ramload         (ramload),
    .ramstate        (ramstate),
    .bus_busy_cycles (bus_busy_cycles),
    .bus_xfers       (bus_xfers)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: who holds the bus (if anyone), where round-robin starts, counters.
  bit          m_busy;
  int          m_core;
  bit          m_is_i;
  int          m_ptr;
  int unsigned m_busy_cnt;
  int unsigned m_xfers;
  bit          d_done [N];
  bit          i_done [N];
  int          obs_q [$];
  int          ren_cycles;
  int          wen_only_cycles;

  task automatic model_reset();
    m_busy     = 1'b0;
    m_core     = 0;
    m_is_i     = 1'b0;
    m_ptr      = 0;
    m_busy_cnt = 0;
    m_xfers    = 0;
    for (int k = 0; k < N; k++) begin
      d_done[k] = 1'b0;
      i_done[k] = 1'b0;
    end
  endtask

  function automatic int pick(input logic [N-1:0] mask, input int start);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic clear_inputs();
    dREN = '0; dWEN = '0; iREN = '0;
    daddr = '0; dstore = '0; iaddr = '0;
    ramload = '0; ramstate = FREE;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Sample at the falling edge, compare against the model, advance the model.
  task automatic step();
    logic [N-1:0]       e_dw, e_iw;
    logic [N-1:0][31:0] e_dl, e_il;
    logic               e_ren, e_wen;
    logic [31:0]        e_addr, e_store;
    int                 c;
    bit                 live;
    @(negedge CLK);
    e_dw = '1; e_iw = '1; e_dl = '0; e_il = '0;
    e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
    for (int k = 0; k < N; k++) begin
      d_done[k] = 1'b0;
      i_done[k] = 1'b0;
    end
    check_eq("bus_busy_cycles", bus_busy_cycles, StatsEn ? 64'(m_busy_cnt) : 64'd0);
    check_eq("bus_xfers", bus_xfers, StatsEn ? 64'(m_xfers) : 64'd0);
    if (!m_busy) begin
      c = pick(dREN | dWEN, m_ptr);
      if (c >= 0) begin
        m_busy = 1'b1; m_core = c; m_is_i = 1'b0;
      end else begin
        c = pick(iREN, m_ptr);
        if (c >= 0) begin
          m_busy = 1'b1; m_core = c; m_is_i = 1'b1;
        end
      end
    end else begin
      m_busy_cnt++;
      c = m_core;
      live = m_is_i ? iREN[c] : (dREN[c] | dWEN[c]);
      if (!live) begin
        m_busy = 1'b0;
      end else begin
        if (m_is_i) begin
          e_ren = 1'b1; e_addr = iaddr[c];
        end else begin
          e_addr = daddr[c];
          if (dWEN[c]) begin
            e_wen = 1'b1; e_store = dstore[c];
          end else begin
            e_ren = 1'b1;
          end
        end
        if (ramstate == ACCESS) begin
          if (m_is_i) begin
            e_iw[c] = 1'b0; e_il[c] = ramload; i_done[c] = 1'b1;
          end else begin
            e_dw[c] = 1'b0; e_dl[c] = ramload; d_done[c] = 1'b1;
          end
          m_busy = 1'b0;
          m_ptr  = (c + 1) % N;
          m_xfers++;
        end
      end
    end
    check_eq("dwait", 64'(dwait), 64'(e_dw));
    check_eq("iwait", 64'(iwait), 64'(e_iw));
    check_eq("dload", 64'(dload), 64'(e_dl));
    check_eq("iload", 64'(iload), 64'(e_il));
    check_eq("ramREN", 64'(ramREN), 64'(e_ren));
    check_eq("ramWEN", 64'(ramWEN), 64'(e_wen));
    check_eq("ramaddr", 64'(ramaddr), 64'(e_addr));
    check_eq("ramstore", 64'(ramstore), 64'(e_store));
    for (int k = 0; k < N; k++) begin
      if (dwait[k] === 1'b0) obs_q.push_back(k);
      if (iwait[k] === 1'b0) obs_q.push_back(8 + k);
    end
    if (ramREN === 1'b1) ren_cycles++;
    if (ramWEN === 1'b1 && ramREN === 1'b0) wen_only_cycles++;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_dwait"}, 64'(dwait), 64'(2'b11));
    check_eq({tag, "_iwait"}, 64'(iwait), 64'(2'b11));
    check_eq({tag, "_loads"}, 64'({dload, iload}), 64'd0);
    check_eq({tag, "_ram"}, {30'd0, ramREN, ramWEN, ramaddr | ramstore}, 64'd0);
  endtask

  // Called at a falling edge; returns at the falling edge after release.
  task automatic reset_pulse();
    n_rst = 1'b0;
    clear_inputs();
    #2;
    check_idle_outputs("rst");
    model_reset();
    @(negedge CLK);
    n_rst = 1'b1;
  endtask

  task automatic drive_random();
    int r;
    for (int c = 0; c < N; c++) begin
      if (d_done[c]) begin
        dREN[c] = 1'b0; dWEN[c] = 1'b0;
      end else if ((dREN[c] | dWEN[c]) && $urandom_range(0, 49) == 0) begin
        dREN[c] = 1'b0; dWEN[c] = 1'b0;
      end else if (!(dREN[c] | dWEN[c]) && $urandom_range(0, 2) == 0) begin
        r = int'($urandom_range(0, 2));
        dREN[c]   = (r != 1);
        dWEN[c]   = (r != 0);
        daddr[c]  = $urandom;
        dstore[c] = $urandom;
      end
      if (i_done[c]) begin
        iREN[c] = 1'b0;
      end else if (iREN[c] && $urandom_range(0, 49) == 0) begin
        iREN[c] = 1'b0;
      end else if (!iREN[c] && $urandom_range(0, 2) == 0) begin
        iREN[c]  = 1'b1;
        iaddr[c] = $urandom;
      end
    end
    r = int'($urandom_range(0, 99));
    if (r < 20)      ramstate = FREE;
    else if (r < 50) ramstate = BUSY;
    else if (r < 85) ramstate = ACCESS;
    else             ramstate = ERROR;
    ramload = $urandom;
  endtask

  initial begin
    n_rst = 1'b0;
    clear_inputs();
    model_reset();
    ren_cycles = 0;
    wen_only_cycles = 0;
    #12;
    check_idle_outputs("por");
    @(negedge CLK);
    n_rst = 1'b1;

    // Single read: BUSY, BUSY, ACCESS.
    cyc(); dREN[0] = 1'b1; daddr[0] = 32'h100; ramstate = FREE;
    obs_q.delete(); ren_cycles = 0;
    step();
    cyc(); ramstate = BUSY; step();
    cyc(); step();
    cyc(); ramstate = ACCESS; ramload = 32'hDEAD_BEEF; step();
    cyc(); dREN[0] = 1'b0; ramstate = FREE; step();
    check_eq("t1_ren_cycles", 64'(ren_cycles), 64'd3);
    check_eq("t1_n_done", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() > 0) check_eq("t1_who", 64'(obs_q[0]), 64'd0);

    // Dcache write beats a simultaneous icache read.
    cyc(); iREN[0] = 1'b1; iaddr[0] = 32'h40;
    dWEN[1] = 1'b1; daddr[1] = 32'h3100; dstore[1] = 32'h5; ramstate = ACCESS;
    obs_q.delete();
    step();
    cyc(); step();
    cyc(); dWEN[1] = 1'b0; step();
    cyc(); step();
    cyc(); iREN[0] = 1'b0; step();
    check_eq("t2_n_done", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() == 2) begin
      check_eq("t2_first", 64'(obs_q[0]), 64'd1);
      check_eq("t2_second", 64'(obs_q[1]), 64'd8);
    end

    // Round-robin between two continuously requesting dcaches.
    reset_pulse();
    obs_q.delete();
    for (int k = 0; k < 8; k++) begin
      cyc(); dREN = '1; ramstate = ACCESS;
      daddr[0] = $urandom; daddr[1] = $urandom; ramload = $urandom;
      step();
    end
    cyc(); dREN = '0; step();
    check_eq("t3_n_done", 64'(obs_q.size()), 64'd4);
    if (obs_q.size() == 4) begin
      check_eq("t3_order", {32'(obs_q[0]), 32'(obs_q[1])}, {32'd0, 32'd1});
      check_eq("t3_order2", {32'(obs_q[2]), 32'(obs_q[3])}, {32'd0, 32'd1});
    end

    // Simultaneous read and write: write only.
    cyc(); dREN[1] = 1'b1; dWEN[1] = 1'b1; daddr[1] = 32'h200; dstore[1] = 32'hA5A5;
    ramstate = ACCESS; obs_q.delete(); wen_only_cycles = 0; ren_cycles = 0;
    step();
    cyc(); step();
    cyc(); dREN = '0; dWEN = '0; step();
    check_eq("t4_wen_only", 64'(wen_only_cycles), 64'd1);
    check_eq("t4_ren", 64'(ren_cycles), 64'd0);
    check_eq("t4_n_done", 64'(obs_q.size()), 64'd1);

    // ERROR stalls, then ACCESS completes.
    cyc(); dREN[0] = 1'b1; daddr[0] = 32'h300; ramstate = ERROR; obs_q.delete();
    step();
    for (int k = 0; k < 5; k++) begin
      cyc(); step();
    end
    check_eq("t5_err_no_done", 64'(obs_q.size()), 64'd0);
    cyc(); ramstate = ACCESS; ramload = 32'h1234_5678; step();
    check_eq("t5_done", 64'(obs_q.size()), 64'd1);
    cyc(); dREN = '0; ramstate = FREE; step();

    // Owner drops its request mid-BUSY; pointer stays on core 1.
    cyc(); dREN[0] = 1'b1; ramstate = BUSY; obs_q.delete();
    step();
    cyc(); step();
    cyc(); dREN[0] = 1'b0; step();
    cyc(); step();
    check_eq("t5_drop_no_done", 64'(obs_q.size()), 64'd0);
    cyc(); dREN = '1; ramstate = ACCESS; step();
    cyc(); step();
    cyc(); dREN = '0; step();
    check_eq("t5_ptr_kept", 64'(obs_q.size() > 0 ? obs_q[0] : -1), 64'd1);

    // Asynchronous reset while in DBUS.
    cyc(); dREN[0] = 1'b1; daddr[0] = 32'h400; ramstate = BUSY;
    step();
    cyc();
    check_eq("t6_in_dbus", 64'(ramREN), 64'd1);
    n_rst = 1'b0;
    #1;
    check_idle_outputs("t6_rst");
    clear_inputs();
    model_reset();
    @(negedge CLK);
    n_rst = 1'b1;

    // Three transfers with two bus cycles each.
    reset_pulse();
    for (int k = 0; k < 3; k++) begin
      cyc(); dREN[0] = 1'b1; daddr[0] = 32'h500 + 32'(k); ramstate = FREE; step();
      cyc(); ramstate = BUSY; step();
      cyc(); ramstate = ACCESS; step();
      cyc(); dREN[0] = 1'b0; ramstate = FREE; step();
    end
    cyc(); step();
    check_eq("t7_xfers", 64'(bus_xfers), StatsEn ? 64'd3 : 64'd0);
    check_eq("t7_busy", 64'(bus_busy_cycles), StatsEn ? 64'd6 : 64'd0);

    // Randomized traffic.
    reset_pulse();
    for (int k = 0; k < 600; k++) begin
      cyc();
      drive_random();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
